// File: rtl/sync_pulse_pkg.sv
// sync_pulse_pkg: shared default synchronizer depth for the sync_pulse block
package sync_pulse_pkg;
  localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/sync_pulse_if.sv
// sync_pulse_if: event strobe bundle, ina (async event in) and outb (one-cycle clkb pulse out)
interface sync_pulse_if;
  logic ina;
  logic outb;
  modport master (output ina, input outb);
  modport slave (input ina, output outb);
endinterface

// File: rtl/sync_bit_chain.sv
// sync_bit_chain: N-flop metastability synchronizer, ports clkb/rstb (sync active-high), d async in, q synchronized out
module sync_bit_chain #(
  parameter int N = 2
) (
  input  logic clkb,
  input  logic rstb,
  input  logic d,
  output logic q
);
  (* async_reg = "true" *) logic [N-1:0] s;
  always_ff @(posedge clkb)
    if (rstb) s <= '0;
    else s <= {s[N-2:0], d};
  assign q = s[N-1];
endmodule

// File: rtl/sync_pulse.sv
// sync_pulse: async ina to one registered clkb-cycle pulse on outb per rising edge, ports clkb, rstb (sync active-high), bus (ina/outb)
module sync_pulse
  import sync_pulse_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic clkb,
  input logic rstb,
  sync_pulse_if.slave bus
);
  logic ina_s;
  logic prev;
  logic outb;
  sync_bit_chain #(.N(SYNC_STAGES)) u_sync (
    .clkb (clkb),
    .rstb (rstb),
    .d    (bus.ina),
    .q    (ina_s)
  );
  always_ff @(posedge clkb)
    if (rstb) begin
      prev <= 1'b0;
      outb <= 1'b0;
    end else begin
      prev <= ina_s;
      outb <= ina_s & ~prev;
    end
  assign bus.outb = outb;
endmodule

// File: tb/tb_sync_pulse.sv
// tb_sync_pulse: table-driven scoreboard bench for sync_pulse
`timescale 1ns/100ps
module tb_sync_pulse;
  localparam int STAGES = 2;
  typedef struct {
    logic lvl;
    int   n;
    bit   exp;
  } vec_t;
  logic clkb = 1'b0;
  logic rstb = 1'b1;
  sync_pulse_if bus ();
  sync_pulse #(.SYNC_STAGES(STAGES)) dut (
    .clkb (clkb),
    .rstb (rstb),
    .bus  (bus)
  );
  always #1.5 clkb = ~clkb;
  int cyc = 0;
  int asserts = 0;
  int errs = 0;
  int pulses = 0;
  int exp_pulses = 0;
  int free_pulses = 0;
  bit mon_en = 1'b0;
  bit free = 1'b0;
  logic last = 1'b0;
  int q[$];
  vec_t tbl[$];
  always @(posedge clkb) cyc <= cyc + 1;
  always @(negedge clkb) begin
    logic e;
    if (mon_en) begin
      asserts++;
      if (free) begin
        if ($isunknown(bus.outb) || (bus.outb === 1'b1 && last === 1'b1)) begin
          errs++;
          $display("FAIL subperiod cyc=%0d outb=%b prev_outb=%b required single-cycle non-X", cyc, bus.outb, last);
        end
        if (bus.outb === 1'b1) free_pulses++;
      end else begin
        e = q.size() > 0 && q[0] == cyc;
        if (e) void'(q.pop_front());
        while (q.size() > 0 && q[0] < cyc) void'(q.pop_front());
        if (bus.outb !== e) begin
          errs++;
          $display("FAIL outb cyc=%0d actual=%b required=%b", cyc, bus.outb, e);
        end
        if (bus.outb === 1'b1) pulses++;
      end
      last = bus.outb;
    end
  end
  task automatic expect_pulse();
    q.push_back(cyc + STAGES + 1);
    exp_pulses++;
  endtask
  task automatic apply(input vec_t v);
    @(negedge clkb);
    bus.ina = v.lvl;
    if (v.exp) expect_pulse();
    repeat (v.n - 1) @(negedge clkb);
  endtask
  task automatic check(input string name, input bit ok, input int act, input int req);
    asserts++;
    if (!ok) begin
      errs++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask
  initial begin
    bus.ina = 1'b0;
    tbl.push_back('{1'b1, 2, 1'b1});
    tbl.push_back('{1'b0, 10, 1'b0});
    tbl.push_back('{1'b1, 20, 1'b1});
    tbl.push_back('{1'b0, 2, 1'b0});
    tbl.push_back('{1'b1, 2, 1'b1});
    tbl.push_back('{1'b0, 10, 1'b0});
    for (int i = 0; i < 5; i++) begin
      tbl.push_back('{1'b1, 2, 1'b1});
      tbl.push_back('{1'b0, 10, 1'b0});
    end
    tbl.push_back('{1'b1, 2, 1'b1});
    tbl.push_back('{1'b0, 1, 1'b0});
    tbl.push_back('{1'b1, 2, 1'b1});
    tbl.push_back('{1'b0, 10, 1'b0});
    @(posedge clkb);
    mon_en = 1'b1;
    @(negedge clkb);
    bus.ina = 1'b1;
    @(negedge clkb);
    rstb = 1'b0;
    bus.ina = 1'b0;
    repeat (10) @(negedge clkb);
    foreach (tbl[i]) apply(tbl[i]);
    @(negedge clkb);
    bus.ina = 1'b1;
    @(negedge clkb);
    rstb = 1'b1;
    bus.ina = 1'b0;
    @(negedge clkb);
    rstb = 1'b0;
    repeat (8) @(negedge clkb);
    rstb = 1'b1;
    bus.ina = 1'b1;
    @(negedge clkb);
    rstb = 1'b0;
    expect_pulse();
    repeat (12) @(negedge clkb);
    bus.ina = 1'b0;
    repeat (8) @(negedge clkb);
    bus.ina = 1'b1;
    repeat (2) @(negedge clkb);
    rstb = 1'b1;
    @(negedge clkb);
    rstb = 1'b0;
    expect_pulse();
    repeat (8) @(negedge clkb);
    bus.ina = 1'b0;
    repeat (8) @(negedge clkb);
    free = 1'b1;
    repeat (20) begin
      bus.ina = 1'b1;
      #1;
      bus.ina = 1'b0;
      #1;
    end
    repeat (7) @(negedge clkb);
    free = 1'b0;
    repeat (10) @(negedge clkb);
    check("pending_pulses", q.size() == 0, q.size(), 0);
    check("pulse_count", pulses == exp_pulses, pulses, exp_pulses);
    check("subperiod_count", free_pulses <= 20, free_pulses, 20);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errs);
    $finish;
  end
endmodule
